// File: rtl/dijkstra_pkg.sv
// Shared types and build defaults for the shortest-path engine.
// The `ifndef guards let a project-wide constants file override these defaults.
`ifndef DEFAULT_MAX_NODES
`define DEFAULT_MAX_NODES 8
`endif
`ifndef DEFAULT_INDEX_WIDTH
`define DEFAULT_INDEX_WIDTH 3
`endif
`ifndef DEFAULT_VALUE_WIDTH
`define DEFAULT_VALUE_WIDTH 8
`endif
`ifndef UNVISITED
`define UNVISITED 1'b0
`endif

package dijkstra_pkg;

    localparam int unsigned DEF_MAX_NODES   = `DEFAULT_MAX_NODES;
    localparam int unsigned DEF_INDEX_WIDTH = `DEFAULT_INDEX_WIDTH;
    localparam int unsigned DEF_VALUE_WIDTH = `DEFAULT_VALUE_WIDTH;

    // All-ones distance/weight means "no edge" or "unreached".
    localparam logic [DEF_VALUE_WIDTH-1:0] INF = '1;

    typedef logic [DEF_VALUE_WIDTH-1:0] dist_t;
    typedef logic [DEF_VALUE_WIDTH-1:0] weight_t;
    typedef logic [DEF_INDEX_WIDTH-1:0] index_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SELECT = 3'd1,
        ST_FETCH  = 3'd2,
        ST_RELAX  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

endpackage

// File: rtl/dijkstra_relax_cmp.sv
// Relaxation compare: widened add, saturation check and update decision.
module relax_cmp #(
    parameter int unsigned VALUE_WIDTH = `DEFAULT_VALUE_WIDTH
) (
    input  logic [VALUE_WIDTH-1:0] cur_dist,
    input  logic [VALUE_WIDTH-1:0] weight,
    input  logic [VALUE_WIDTH-1:0] old_dist,
    input  logic                   unvisited,
    output logic [VALUE_WIDTH-1:0] sum_c,
    output logic                   update_c
);

    localparam logic [VALUE_WIDTH-1:0] VAL_INF = '1;

    logic [VALUE_WIDTH:0] wide_sum;

    // Extra carry bit so a saturating sum is seen as >= INF rather than wrapping.
    always_comb begin
        wide_sum = {1'b0, cur_dist} + {1'b0, weight};
        sum_c    = wide_sum[VALUE_WIDTH-1:0];
        update_c = (weight != VAL_INF)
                && unvisited
                && (wide_sum < {1'b0, VAL_INF})
                && (wide_sum < {1'b0, old_dist});
    end

endmodule

// File: rtl/dijkstra_relax.sv
// Control and relaxation stage of the shortest-path engine.
// Optional predecessor tracking is enabled by defining DIJKSTRA_PRED_EN.
module dijkstra_relax
    import dijkstra_pkg::*;
#(
    parameter int unsigned MAX_NODES   = `DEFAULT_MAX_NODES,
    parameter int unsigned INDEX_WIDTH = `DEFAULT_INDEX_WIDTH,
    parameter int unsigned VALUE_WIDTH = `DEFAULT_VALUE_WIDTH
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               start,
    input  logic [INDEX_WIDTH-1:0]             source,
    output logic                               busy,
    output logic                               done,
    input  logic [INDEX_WIDTH-1:0]             min_index,
    input  logic [VALUE_WIDTH-1:0]             min_value,
    output logic [MAX_NODES-1:0]               visited_vector,
    output logic [MAX_NODES*VALUE_WIDTH-1:0]   dist_vector,
    output logic                               adj_rd_en,
    output logic [INDEX_WIDTH-1:0]             adj_rd_row,
    output logic [INDEX_WIDTH-1:0]             adj_rd_col,
    input  logic [VALUE_WIDTH-1:0]             adj_rd_data
`ifdef DIJKSTRA_PRED_EN
    ,
    output logic [MAX_NODES*INDEX_WIDTH-1:0]   prev_vector
`endif
);

    localparam int unsigned CNT_W = $clog2(MAX_NODES + 1);
    localparam logic [VALUE_WIDTH-1:0] VAL_INF = '1;
    localparam logic VISITED = !`UNVISITED;

    state_t                   state;
    logic [VALUE_WIDTH-1:0]   dist_q [MAX_NODES];
    logic [MAX_NODES-1:0]     visited_q;
    logic [INDEX_WIDTH-1:0]   cur;
    logic [INDEX_WIDTH-1:0]   nbr;
    logic [VALUE_WIDTH-1:0]   cur_dist;
    logic [CNT_W-1:0]         settled;
`ifdef DIJKSTRA_PRED_EN
    logic [INDEX_WIDTH-1:0]   prev_q [MAX_NODES];
`endif

    logic [VALUE_WIDTH-1:0]   sum_c;
    logic                     update_c;

    relax_cmp #(
        .VALUE_WIDTH (VALUE_WIDTH)
    ) u_relax_cmp (
        .cur_dist  (cur_dist),
        .weight    (adj_rd_data),
        .old_dist  (dist_q[nbr]),
        .unvisited (visited_q[nbr] == `UNVISITED),
        .sum_c     (sum_c),
        .update_c  (update_c)
    );

    assign visited_vector = visited_q;

    for (genvar g = 0; g < MAX_NODES; g++) begin : g_flat
        assign dist_vector[g*VALUE_WIDTH +: VALUE_WIDTH] = dist_q[g];
`ifdef DIJKSTRA_PRED_EN
        assign prev_vector[g*INDEX_WIDTH +: INDEX_WIDTH] = prev_q[g];
`endif
    end

    // Run sequencer: select one node, then fetch/relax every column of its row.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            adj_rd_en  <= 1'b0;
            adj_rd_row <= '0;
            adj_rd_col <= '0;
            visited_q  <= {MAX_NODES{`UNVISITED}};
            cur        <= '0;
            nbr        <= '0;
            cur_dist   <= '0;
            settled    <= '0;
            for (int i = 0; i < MAX_NODES; i++) begin
                dist_q[i] <= VAL_INF;
`ifdef DIJKSTRA_PRED_EN
                prev_q[i] <= INDEX_WIDTH'(i);
`endif
            end
        end else begin
            done      <= 1'b0;
            adj_rd_en <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        // An out-of-range source matches no slot, so the run ends at once.
                        for (int i = 0; i < MAX_NODES; i++) begin
                            dist_q[i] <= (source == INDEX_WIDTH'(i)) ? '0 : VAL_INF;
`ifdef DIJKSTRA_PRED_EN
                            prev_q[i] <= INDEX_WIDTH'(i);
`endif
                        end
                        visited_q <= {MAX_NODES{`UNVISITED}};
                        settled   <= '0;
                        busy      <= 1'b1;
                        state     <= ST_SELECT;
                    end
                end
                ST_SELECT: begin
                    if ((settled == CNT_W'(MAX_NODES)) || (min_value == VAL_INF)) begin
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        for (int i = 0; i < MAX_NODES; i++) begin
                            if (min_index == INDEX_WIDTH'(i)) visited_q[i] <= VISITED;
                        end
                        cur        <= min_index;
                        cur_dist   <= min_value;
                        nbr        <= '0;
                        settled    <= settled + CNT_W'(1);
                        adj_rd_en  <= 1'b1;
                        adj_rd_row <= min_index;
                        adj_rd_col <= '0;
                        state      <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    state <= ST_RELAX;
                end
                ST_RELAX: begin
                    if (update_c) begin
                        dist_q[nbr] <= sum_c;
`ifdef DIJKSTRA_PRED_EN
                        prev_q[nbr] <= cur;
`endif
                    end
                    if (nbr == INDEX_WIDTH'(MAX_NODES - 1)) begin
                        state <= ST_SELECT;
                    end else begin
                        nbr        <= nbr + INDEX_WIDTH'(1);
                        adj_rd_en  <= 1'b1;
                        adj_rd_row <= cur;
                        adj_rd_col <= nbr + INDEX_WIDTH'(1);
                        state      <= ST_FETCH;
                    end
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dijkstra_relax.sv
// Directed bench for dijkstra_relax with a behavioural min-heap and adjacency memory.
module tb_dijkstra_relax;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  source;
    logic        busy;
    logic        done;
    logic [2:0]  min_index;
    logic [7:0]  min_value;
    logic [7:0]  visited_vector;
    logic [63:0] dist_vector;
    logic        adj_rd_en;
    logic [2:0]  adj_rd_row;
    logic [2:0]  adj_rd_col;
    logic [7:0]  adj_rd_data;
`ifdef DIJKSTRA_PRED_EN
    logic [23:0] prev_vector;
`endif

    logic [7:0]  adj [8][8];
    int          checks;
    int          errors;
    int          stray_reads;

    dijkstra_relax dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .source         (source),
        .busy           (busy),
        .done           (done),
        .min_index      (min_index),
        .min_value      (min_value),
        .visited_vector (visited_vector),
        .dist_vector    (dist_vector),
        .adj_rd_en      (adj_rd_en),
        .adj_rd_row     (adj_rd_row),
        .adj_rd_col     (adj_rd_col),
        .adj_rd_data    (adj_rd_data)
`ifdef DIJKSTRA_PRED_EN
        ,
        .prev_vector    (prev_vector)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational min-selection over unvisited nodes; lowest index wins ties.
    always_comb begin
        min_index = 3'd0;
        min_value = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            if (visited_vector[i] == 1'b0 && dist_vector[i*8 +: 8] < min_value) begin
                min_value = dist_vector[i*8 +: 8];
                min_index = 3'(i);
            end
        end
    end

    always @(posedge clk) begin
        if (adj_rd_en) adj_rd_data <= adj[adj_rd_row][adj_rd_col];
    end

    always @(negedge clk) begin
        if (rst_n && adj_rd_en && !busy) stray_reads++;
    end

    task automatic clear_graph();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                adj[r][c] = 8'hFF;
    endtask

    // Drive start for one cycle; cyc is the cycle index at which done is seen.
    task automatic run(input logic [2:0] src, input int extra_start_at, output int cyc);
        @(negedge clk);
        start  = 1'b1;
        source = src;
        cyc    = 0;
        while (cyc < 2000) begin
            @(negedge clk);
            cyc++;
            start = (cyc == extra_start_at);
            if (cyc == 1 && busy !== 1'b1) begin
                errors++;
                $display("FAIL busy_at_cycle1: got %b want 1", busy);
            end
            if (done === 1'b1) break;
        end
        start = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_reset_values(input string tag);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL %s busy: got %b want 0", tag, busy); end
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL %s done: got %b want 0", tag, done); end
        checks++;
        if (adj_rd_en !== 1'b0) begin errors++; $display("FAIL %s adj_rd_en: got %b want 0", tag, adj_rd_en); end
        checks++;
        if (dist_vector !== {64{1'b1}}) begin errors++; $display("FAIL %s dist: got %h want all ff", tag, dist_vector); end
        checks++;
        if (visited_vector !== 8'h00) begin errors++; $display("FAIL %s visited: got %h want 00", tag, visited_vector); end
`ifdef DIJKSTRA_PRED_EN
        checks++;
        if (prev_vector !== {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0}) begin
            errors++; $display("FAIL %s prev: got %h want identity", tag, prev_vector);
        end
`endif
    endtask

    task automatic check_run(input string tag, input int cyc, input int exp_cyc,
                             input logic [63:0] exp_dist, input logic [7:0] exp_vis);
        checks++;
        if (cyc !== exp_cyc) begin errors++; $display("FAIL %s done_cycle: got %0d want %0d", tag, cyc, exp_cyc); end
        checks++;
        if (dist_vector !== exp_dist) begin errors++; $display("FAIL %s dist: got %h want %h", tag, dist_vector, exp_dist); end
        checks++;
        if (visited_vector !== exp_vis) begin errors++; $display("FAIL %s visited: got %h want %h", tag, visited_vector, exp_vis); end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL %s idle_after: busy=%b done=%b want 0 0", tag, busy, done); end
    endtask

    task automatic test_reset(input string tag);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_values(tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_chain();
        int cyc;
        clear_graph();
        adj[0][1] = 8'd3;
        adj[1][2] = 8'd4;
        run(3'd0, -1, cyc);
        check_run("chain", cyc, 53, {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'd7, 8'd3, 8'd0}, 8'h07);
    endtask

    task automatic test_full_graph();
        int cyc;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                adj[r][c] = (r == c) ? 8'hFF : 8'd1;
        run(3'd5, -1, cyc);
        check_run("full", cyc, 138, {8'd1, 8'd1, 8'd0, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1}, 8'hFF);
    endtask

    task automatic test_saturation();
        int cyc;
        clear_graph();
        adj[0][1] = 8'd254;
        adj[1][2] = 8'd10;
        run(3'd0, -1, cyc);
        check_run("saturate", cyc, 36, {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'd254, 8'd0}, 8'h03);
    endtask

    task automatic test_shorter_path();
        int cyc;
        clear_graph();
        adj[0][1] = 8'd10;
        adj[0][2] = 8'd2;
        adj[2][1] = 8'd3;
        run(3'd0, -1, cyc);
        check_run("shorter", cyc, 53, {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'd2, 8'd5, 8'd0}, 8'h07);
`ifdef DIJKSTRA_PRED_EN
        checks++;
        if (prev_vector !== {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd0, 3'd2, 3'd0}) begin
            errors++; $display("FAIL shorter prev: got %h want %h", prev_vector,
                               {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd0, 3'd2, 3'd0});
        end
`endif
    endtask

    task automatic test_reset_mid_run();
        int cyc;
        clear_graph();
        adj[0][1] = 8'd3;
        adj[1][2] = 8'd4;
        @(negedge clk);
        start  = 1'b1;
        source = 3'd0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        check_reset_values("midrun_reset");
        @(negedge clk);
        rst_n = 1'b1;
        run(3'd0, 10, cyc);
        check_run("after_reset", cyc, 53, {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'd7, 8'd3, 8'd0}, 8'h07);
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        stray_reads = 0;
        rst_n       = 1'b0;
        start       = 1'b0;
        source      = 3'd0;
        clear_graph();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        test_reset("reset_initial");
        test_chain();
        test_reset("reset_idle");
        test_full_graph();
        test_saturation();
        test_shorter_path();
        test_reset_mid_run();

        checks++;
        if (stray_reads !== 0) begin
            errors++; $display("FAIL stray_reads: got %0d want 0", stray_reads);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
